// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - cache eviction FIFO with background RAM drain and read-miss forwarding
module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wb_valid,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       wb_ready,
    input  logic                       rd_req,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [ADDR_W-1:0]          ram_address,
    output logic [DATA_W-1:0]          ram_data,
    output logic                       ram_wren,
    input  logic [DATA_W-1:0]          ram_q,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT} state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    valid_q;
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_wren_q, ram_wren_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                push, pop, co_hit, fwd_hit;
    logic [PTR_W-1:0]    co_idx;
    logic [DATA_W-1:0]   fwd_data, head_data;

    assign wb_ready = (count_q < CNT_W'(DEPTH));
    assign push     = wb_valid && wb_ready;
    assign pop      = (state_q == WRITE);

    // The entry leaving in WRITE already has its data in ram_data, so it must not absorb a coalesce.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!co_hit && valid_q[i] && (addr_q[i] == wb_addr) &&
                !(pop && (PTR_W'(i) == head_q))) begin
                co_hit = 1'b1;
                co_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!fwd_hit && valid_q[i] && (addr_q[i] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[i];
            end
        end
        if (push && (wb_addr == rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data;
        end
    end

    // A push coalescing into head on the edge that launches its write must reach RAM too.
    assign head_data = (push && co_hit && (co_idx == head_q)) ? wb_data : data_q[head_q];

    always_comb begin
        count_d = count_q;
        if (push && !co_hit && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !(push && !co_hit))
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (push && !co_hit) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            if (co_hit) begin
                data_q[co_idx] <= wb_data;
            end else begin
                addr_q[tail_q] <= wb_addr;
                data_q[tail_q] <= wb_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_req)
                    state_d = fwd_hit ? IDLE : RD_ISSUE;
                else if (count_q != '0)
                    state_d = WRITE;
            end
            WRITE:    state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    if (fwd_hit) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = fwd_data;
                    end else begin
                        ram_address_d = rd_addr;
                    end
                end else if (count_q != '0) begin
                    ram_address_d = addr_q[head_q];
                    ram_data_d    = head_data;
                    ram_wren_d    = 1'b1;
                end
            end
            RD_WAIT: begin
                rd_data_d  = ram_q;
                rd_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_ready    = (state_q == IDLE);
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign count       = count_q;
endmodule
